// File: rtl/sram_mem_ctrl_if.sv
// Bus bundle between the MEM stage, sram_mem_ctrl and the external 16-bit SRAM pads.
// The controller uses the slave modport; the pipeline/pad environment uses master.
interface sram_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 18
);
  logic              MEM_R_EN;
  logic              MEM_W_EN;
  logic [31:0]       Address;
  logic [31:0]       Write_Data;
  logic [31:0]       Read_Data;
  logic              Ready;
  logic [ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]       SRAM_DQ_out;
  logic [15:0]       SRAM_DQ_in;
  logic              SRAM_DQ_oe;
  logic              SRAM_WE_N;

  modport slave (
    input  MEM_R_EN, MEM_W_EN, Address, Write_Data, SRAM_DQ_in,
    output Read_Data, Ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );

  modport master (
    output MEM_R_EN, MEM_W_EN, Address, Write_Data, SRAM_DQ_in,
    input  Read_Data, Ready, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe, SRAM_WE_N
  );
endinterface

// File: rtl/sram_mem_ctrl.sv
// Memory-stage controller: one 32-bit LDR/STR becomes two 16-bit SRAM phases (low half, then
// high half), each WAIT_CYCLES long. Ready is low while a request is outstanding.
// Optional macro SRAM_LAST_WORD_CACHE_EN: keep the last completed word so a repeated read
// completes in one cycle without touching the SRAM.
module sram_mem_ctrl #(
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_mem_ctrl_if.slave bus
);

  localparam int unsigned WordW   = ADDR_W - 1;
  localparam logic [3:0]  LastCnt = 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q;
  logic [WordW-1:0]  word_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       dq_q, dq_d;
  logic              oe_q, oe_d;
  logic              we_n_q, we_n_d;

  logic              req;
  logic              last;
  logic              wr_next;
  logic              accept;
  logic              hit;
  logic [WordW-1:0]  word_in;

  assign req     = bus.MEM_R_EN | bus.MEM_W_EN;
  assign last    = (cnt_q == LastCnt);
  // Subtraction wraps for addresses below BASE_ADDR; only the SRAM-visible word bits are kept.
  assign word_in = WordW'((bus.Address - BASE_ADDR) >> 2);
  assign accept  = (state_q == StIdle) && req;

`ifdef SRAM_LAST_WORD_CACHE_EN
  logic             c_valid_q;
  logic [WordW-1:0] c_word_q;
  logic [31:0]      c_data_q;

  // Writes win over reads, so only a pure read may hit.
  assign hit = c_valid_q && bus.MEM_R_EN && !bus.MEM_W_EN && (c_word_q == word_in);

  // Last-word cache, refreshed when the high phase of a full access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_valid_q <= 1'b0;
      c_word_q  <= '0;
      c_data_q  <= '0;
    end else if (state_q == StHi && last) begin
      c_valid_q <= 1'b1;
      c_word_q  <= word_q;
      c_data_q  <= op_wr_q ? wdata_q : {bus.SRAM_DQ_in, rdata_q[15:0]};
    end
  end
`else
  assign hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: phase sequencing and wait-state counting.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          cnt_d   = '0;
          state_d = hit ? StDone : StLo;
        end
      end
      StLo: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StHi;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StHi: begin
        if (last) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered pad outputs and Read_Data.
  always_comb begin
    addr_d  = addr_q;
    dq_d    = dq_q;
    oe_d    = oe_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req && !hit) begin
          addr_d = {word_in, 1'b0};
          dq_d   = bus.Write_Data[15:0];
          oe_d   = bus.MEM_W_EN;
        end
`ifdef SRAM_LAST_WORD_CACHE_EN
        if (req && hit) begin
          rdata_d = c_data_q;
        end
`endif
      end
      StLo: begin
        if (last) begin
          addr_d = {word_q, 1'b1};
          dq_d   = wdata_q[31:16];
          if (!op_wr_q) rdata_d[15:0] = bus.SRAM_DQ_in;
        end
      end
      StHi: begin
        if (last) begin
          oe_d = 1'b0;
          if (!op_wr_q) rdata_d[31:16] = bus.SRAM_DQ_in;
        end
      end
      default: ;
    endcase
    // WE_N low for all but the last cycle of each write phase, so the address only moves
    // while the strobe is high.
    wr_next = (state_q == StIdle) ? bus.MEM_W_EN : op_wr_q;
    we_n_d  = ~(wr_next && (state_d == StLo || state_d == StHi) && (cnt_d != LastCnt));
  end

  // Datapath registers: latched request and registered pad outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q <= 1'b0;
      word_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      dq_q    <= '0;
      oe_q    <= 1'b0;
      we_n_q  <= 1'b1;
    end else begin
      if (accept) begin
        op_wr_q <= bus.MEM_W_EN;
        word_q  <= word_in;
        wdata_q <= bus.Write_Data;
      end
      rdata_q <= rdata_d;
      addr_q  <= addr_d;
      dq_q    <= dq_d;
      oe_q    <= oe_d;
      we_n_q  <= we_n_d;
    end
  end

  assign bus.Read_Data   = rdata_q;
  assign bus.Ready       = ~req | (state_q == StDone);
  assign bus.SRAM_ADDR   = addr_q;
  assign bus.SRAM_DQ_out = dq_q;
  assign bus.SRAM_DQ_oe  = oe_q;
  assign bus.SRAM_WE_N   = we_n_q;

endmodule

// File: doc/sram_mem_ctrl.md
Name: sram_mem_ctrl

Overview:
- Memory-stage controller that sequences one 32-bit data access (LDR/STR) onto a 16-bit external SRAM as two half-word phases with a programmable wait-state count.
- Driven by the decoded MEM_R_EN/MEM_W_EN from the MEM stage.
- Returns Ready low while an access is in flight; the pipeline uses ~Ready as its freeze signal.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM half-word 0.
- ADDR_W, 18, SRAM address width.
- WAIT_CYCLES, 2, cycles per half-word phase; legal range 2..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- MEM_R_EN  in  1  read request; held by the requester until Ready.
- MEM_W_EN  in  1  write request; held by the requester until Ready.
- Address  in  32  byte address; word-aligned.
- Write_Data  in  32  store data.
- Read_Data  out  32  load data; valid in the cycle Ready rises.
- Ready  out  1  0 while a request is pending and not yet completed.
- SRAM_ADDR  out  ADDR_W  half-word address.
- SRAM_DQ_out  out  16  write data to the pad.
- SRAM_DQ_in  in  16  read data from the pad.
- SRAM_DQ_oe  out  1  1 = drive the pad (write phases only).
- SRAM_WE_N  out  1  active-low write strobe.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - Read_Data=0, SRAM_ADDR=0, SRAM_DQ_out=0, SRAM_DQ_oe=0, SRAM_WE_N=1.
  - Reset mid-access aborts the access immediately; SRAM_WE_N rises asynchronously.
- Address map:
  - word = (Address - BASE_ADDR) >> 2, 32-bit subtraction, then truncated.
  - Low phase: SRAM_ADDR = {word[ADDR_W-2:0], 1'b0}.
  - High phase: SRAM_ADDR = {word[ADDR_W-2:0], 1'b1}.
- Request priority: if MEM_W_EN and MEM_R_EN are both 1, the access is a write.
- FSM states: IDLE, LO, HI, DONE.
  - IDLE: on request, latch Address, Write_Data and op, clear counter, go to LO.
  - LO: hold for WAIT_CYCLES cycles. In the last cycle, a read captures SRAM_DQ_in into Read_Data[15:0]. Then go to HI.
  - HI: same as LO, using the high half (Read_Data[31:16] / Write_Data[31:16]). Then go to DONE.
  - DONE: one cycle, then IDLE.
- Outputs during phases:
  - SRAM_ADDR, SRAM_DQ_out and SRAM_DQ_oe are registered and change only on phase entry.
  - Writes: SRAM_WE_N=0 for the first WAIT_CYCLES-1 cycles of each phase and 1 in the phase's last cycle, so address changes only while WE_N is high.
  - Reads never assert WE_N or oe.
- Ready = ~(MEM_R_EN | MEM_W_EN) | (state==DONE), combinational.
- Latency: request first seen in IDLE at cycle 0 gives Ready=1 in cycle 2*WAIT_CYCLES+1. With WAIT_CYCLES=2, Ready=1 at cycle 5.
- Back-to-back accesses: after DONE the FSM returns to IDLE. A request still asserted in IDLE is treated as a new access, so one IDLE cycle separates accesses.
- Request dropped mid-access: the access runs to completion so no half-written word remains. Ready ignores the dropped request and Read_Data is still updated.
- Read_Data holds its value between reads. Writes do not modify Read_Data.
- Address below BASE_ADDR wraps through the 32-bit subtraction; no error is flagged.

Optional Feature:
- Macro: SRAM_LAST_WORD_CACHE_EN.
- Defined:
  - Keep a valid bit, the word address and the 32-bit data of the last completed access.
  - A read that hits a valid entry goes from IDLE directly to DONE (Ready at cycle 1) with no SRAM activity and Read_Data = cached data.
  - Any completed write updates the entry (address and data); any completed read miss updates it.
  - Reset clears the valid bit.
- Undefined: every access takes the full LO/HI sequence.

Test Plan:
- Reset check: rst_n=0 asserted mid-HI of a write -> SRAM_WE_N=1 and SRAM_DQ_oe=0 immediately; after release, state IDLE and Read_Data=0.
- Write timing: MEM_W_EN=1, Address=1028, Write_Data=0xDEADBEEF, WAIT_CYCLES=2 -> SRAM addr 2 gets 0xBEEF, addr 3 gets 0xDEAD; WE_N pulses low one cycle per phase; Ready=1 exactly at cycle 5.
- Read timing: MEM_R_EN=1, Address=1028, SRAM model returns the stored data -> Read_Data=0xDEADBEEF when Ready rises at cycle 5; Ready=0 for cycles 0-4.
- Simultaneous requests: MEM_R_EN=MEM_W_EN=1, Address=1032, Write_Data=0x12345678 -> write performed (SRAM addr 4 = 0x5678, addr 5 = 0x1234) and Read_Data unchanged.
- Request dropped: drop MEM_W_EN in cycle 2 of a write -> both phases still written; Ready=1 from cycle 2; FSM reaches IDLE at cycle 6.
- Cache (macro defined): write 0xCAFEF00D to 1036, then read 1036 -> Ready at cycle 1, Read_Data=0xCAFEF00D, no SRAM_ADDR change. Then read 1040 -> full 5-cycle access.
